// File: rtl/lms_weight_update.sv
// Two-tap LMS weight updater: 4-cycle handshake (IDLE/ERR/UPD/SHIFT) with saturating arithmetic.
// Define LMS_WEIGHT_UPDATE_LEAK_EN to enable leaky-LMS weight decay by 2^-LEAK_SHIFT.
module lms_weight_update #(
  parameter int unsigned MU_SHIFT   = 4,
  parameter int unsigned LEAK_SHIFT = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic signed [7:0] x_in,
  input  logic signed [7:0] y_in,
  input  logic signed [7:0] y_hat_in,
  input  logic              adapt_en,
  output logic signed [7:0] a_hat,
  output logic signed [7:0] b_hat,
  output logic signed [7:0] x_last,
  output logic signed [7:0] y_last,
  output logic signed [7:0] err,
  output logic              out_valid
);

  if (MU_SHIFT > 7) begin : g_mu_range
    $error("MU_SHIFT must be in 0..7");
  end
  if (LEAK_SHIFT < 1 || LEAK_SHIFT > 7) begin : g_leak_range
    $error("LEAK_SHIFT must be in 1..7");
  end

  typedef enum logic [1:0] {StIdle, StErr, StUpd, StShift} state_e;

  state_e state, state_next;

  logic signed [7:0] x_cap, y_cap, y_hat_cap;
  logic              adapt_cap;

  function automatic logic signed [7:0] sat17(input logic signed [16:0] v);
    if (v > 17'sd127)       return 8'sd127;
    else if (v < -17'sd128) return -8'sd128;
    else                    return v[7:0];
  endfunction

  // Error path: 9-bit difference of the captured sample, clamped to 8 bits.
  logic signed [8:0] diff;
  logic signed [7:0] err_sat;
  always_comb begin
    diff = {y_cap[7], y_cap} - {y_hat_cap[7], y_hat_cap};
    if (diff > 9'sd127)       err_sat = 8'sd127;
    else if (diff < -9'sd128) err_sat = -8'sd128;
    else                      err_sat = diff[7:0];
  end

  // Weight path: gradient uses the registered error and the pre-update x_last/y_last.
  logic signed [15:0] prod_a, prod_b, grad_a, grad_b;
  logic signed [16:0] sum_a, sum_b;
  logic signed [7:0]  a_next, b_next;
  always_comb begin
    prod_a = err * x_last;
    prod_b = err * y_last;
    grad_a = prod_a >>> MU_SHIFT;
    grad_b = prod_b >>> MU_SHIFT;
`ifdef LMS_WEIGHT_UPDATE_LEAK_EN
    sum_a = {{9{a_hat[7]}}, a_hat} - {{9{a_hat[7]}}, (a_hat >>> LEAK_SHIFT)}
          + {grad_a[15], grad_a};
    sum_b = {{9{b_hat[7]}}, b_hat} - {{9{b_hat[7]}}, (b_hat >>> LEAK_SHIFT)}
          + {grad_b[15], grad_b};
`else
    sum_a = {{9{a_hat[7]}}, a_hat} + {grad_a[15], grad_a};
    sum_b = {{9{b_hat[7]}}, b_hat} + {grad_b[15], grad_b};
`endif
    a_next = sat17(sum_a);
    b_next = sat17(sum_b);
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= StIdle;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      StIdle:  if (in_valid) state_next = StErr;
      StErr:   state_next = StUpd;
      StUpd:   state_next = StShift;
      StShift: state_next = StIdle;
    endcase
  end

  always_comb begin
    in_ready = (state == StIdle);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      x_cap     <= '0;
      y_cap     <= '0;
      y_hat_cap <= '0;
      adapt_cap <= 1'b0;
      a_hat     <= '0;
      b_hat     <= '0;
      x_last    <= '0;
      y_last    <= '0;
      err       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            x_cap     <= x_in;
            y_cap     <= y_in;
            y_hat_cap <= y_hat_in;
            adapt_cap <= adapt_en;
          end
        end
        StErr: err <= err_sat;
        StUpd: begin
          if (adapt_cap) begin
            a_hat <= a_next;
            b_hat <= b_next;
          end
        end
        StShift: begin
          x_last    <= x_cap;
          y_last    <= y_cap;
          out_valid <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lms_weight_update.sv
// Self-checking bench for lms_weight_update: transaction-level model plus directed literal checks.
module tb_lms_weight_update;
  localparam int unsigned MuShift   = 4;
  localparam int unsigned LeakShift = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] x_in, y_in, y_hat_in;
  logic              adapt_en;
  logic signed [7:0] a_hat, b_hat, x_last, y_last, err;
  logic              out_valid;

  lms_weight_update #(
    .MU_SHIFT  (MuShift),
    .LEAK_SHIFT(LeakShift)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_in     (x_in),
    .y_in     (y_in),
    .y_hat_in (y_hat_in),
    .adapt_en (adapt_en),
    .a_hat    (a_hat),
    .b_hat    (b_hat),
    .x_last   (x_last),
    .y_last   (y_last),
    .err      (err),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int sat8(input int v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // Transaction model: a sample accepted while idle produces its results 3 edges later.
  int m_a, m_b, m_xl, m_yl, m_e;
  int p_a, p_b, p_xl, p_yl, p_e;
  int m_cnt = 0;
  bit m_ov = 1'b0;
  bit m_init = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      m_a = 0; m_b = 0; m_xl = 0; m_yl = 0; m_e = 0;
      m_cnt = 0; m_ov = 1'b0; m_init = 1'b1;
    end else if (m_init) begin
      m_ov = 1'b0;
      if (m_cnt == 0) begin
        if (in_valid) begin
          p_e  = sat8(int'(y_in) - int'(y_hat_in));
          p_xl = int'(x_in);
          p_yl = int'(y_in);
          p_a  = m_a;
          p_b  = m_b;
          if (adapt_en) begin
`ifdef LMS_WEIGHT_UPDATE_LEAK_EN
            p_a = sat8(m_a - (m_a >>> LeakShift) + ((p_e * m_xl) >>> MuShift));
            p_b = sat8(m_b - (m_b >>> LeakShift) + ((p_e * m_yl) >>> MuShift));
`else
            p_a = sat8(m_a + ((p_e * m_xl) >>> MuShift));
            p_b = sat8(m_b + ((p_e * m_yl) >>> MuShift));
`endif
          end
          m_cnt = 3;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_a = p_a; m_b = p_b; m_xl = p_xl; m_yl = p_yl; m_e = p_e;
          m_ov = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("in_ready", int'(in_ready), int'(m_cnt == 0));
      chk("out_valid", int'(out_valid), int'(m_ov));
      if (m_cnt == 0) begin
        chk("err", int'(err), m_e);
        chk("a_hat", int'(a_hat), m_a);
        chk("b_hat", int'(b_hat), m_b);
        chk("x_last", int'(x_last), m_xl);
        chk("y_last", int'(y_last), m_yl);
      end
    end
  end

  task automatic send(input int x, input int y, input int yh, input bit ae);
    int lat;
    @(negedge clk);
    x_in = 8'(x); y_in = 8'(y); y_hat_in = 8'(yh); adapt_en = ae; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 3);
  endtask

  task automatic expect_out(input string tag, input int e, input int a, input int b,
                            input int xl, input int yl);
    chk({tag, ".err"}, int'(err), e);
    chk({tag, ".a_hat"}, int'(a_hat), a);
    chk({tag, ".b_hat"}, int'(b_hat), b);
    chk({tag, ".x_last"}, int'(x_last), xl);
    chk({tag, ".y_last"}, int'(y_last), yl);
  endtask

  int acc;

  initial begin
    reset = 1'b0; in_valid = 1'b0; x_in = '0; y_in = '0; y_hat_in = '0; adapt_en = 1'b0;
    repeat (2) @(negedge clk);
    expect_out("reset", 0, 0, 0, 0, 0);
    chk("reset.in_ready", int'(in_ready), 1);
    chk("reset.out_valid", int'(out_valid), 0);
    reset = 1'b1;

`ifndef LMS_WEIGHT_UPDATE_LEAK_EN
    send(10, 20, 0, 1'b1);
    expect_out("basic1", 20, 0, 0, 10, 20);
    send(5, 30, 0, 1'b1);
    expect_out("basic2", 30, 18, 37, 5, 30);
    send(1, 0, 0, 1'b0);
    expect_out("freeze", 0, 18, 37, 1, 0);
    send(0, -1, 0, 1'b1);
    expect_out("floor", -1, 17, 37, 0, -1);
    send(0, 127, -128, 1'b0);
    expect_out("err_hi", 127, 17, 37, 0, 127);
    send(0, -128, 127, 1'b0);
    expect_out("err_lo", -128, 17, 37, 0, -128);
    send(127, 0, 0, 1'b0);
    send(127, 127, -128, 1'b1);
    chk("clamp1.a_hat", int'(a_hat), 127);
    chk("clamp1.b_hat", int'(b_hat), 37);
    send(127, 127, -128, 1'b1);
    chk("clamp2.a_hat", int'(a_hat), 127);
    chk("clamp2.b_hat", int'(b_hat), 127);
    send(127, 127, -128, 1'b1);
    chk("clamp3.a_hat", int'(a_hat), 127);
`else
    send(10, 20, 0, 1'b1);
    send(5, 30, 0, 1'b1);
`endif

    // Abort an in-flight sample with reset while it sits in UPD.
    @(negedge clk);
    x_in = 8'sd50; y_in = 8'sd100; y_hat_in = 8'sd0; adapt_en = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    expect_out("abort", 0, 0, 0, 0, 0);
    chk("abort.out_valid", int'(out_valid), 0);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort.no_ov", int'(out_valid), 0);
    end

    // Continuous in_valid with inputs changing every cycle.
    acc = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      x_in = 8'($urandom); y_in = 8'($urandom); y_hat_in = 8'($urandom);
      adapt_en = 1'($urandom);
      if (in_ready) acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("accepts_in_40", acc, 10);
    repeat (4) @(negedge clk);

    for (int i = 0; i < 3000; i++) begin
      in_valid = 1'($urandom);
      x_in = 8'($urandom); y_in = 8'($urandom); y_hat_in = 8'($urandom);
      adapt_en = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 99) != 0);
      @(negedge clk);
    end
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (6) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
